ro_freq_meter: RTL and testbench

Parametrised multi-channel ring-oscillator measurement block for the all-digital V/T sensor.
- Controls the enables of N_CH external ring oscillators (different Vt flavours / gate types) and powers only the selected one.
- Counts that oscillator's rising edges over a programmable window of reference-clock cycles.
- Returns the count over a valid/ready handshake, in single-shot or continuous mode.
- Sits between the RO macros and the sensor readout/calibration logic.

---
 rtl/ro_freq_meter.sv | 225 ++++++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter
//
// Multi-channel ring-oscillator frequency meter for the all-digital V/T
// sensor. The block powers exactly one of N_CH external ring oscillators and
// lets it settle for SETTLE reference cycles. It then counts the RO's rising
// edges over a programmable window of reference cycles and hands the count
// to the readout logic over a valid/ready handshake. It supports single-shot
// and continuous measurement modes.
//
// Ports:
//   i_Clk         reference clock, all logic on its rising edge
//   i_Rst_n       asynchronous active-low reset
//   i_Start       measurement request, honoured only while idle
//   i_Stop        abort to idle from any state (beats start and ready)
//   i_Continuous  re-measure after each accepted result
//   i_Ch_Sel      channel to measure, latched when a start is accepted
//   i_Win_Len     window length in reference cycles, 0 behaves as 1
//   i_RO_in       raw RO outputs, asynchronous to i_Clk
//   o_RO_Enable   registered one-hot RO enable, zero while idle
//   o_Count       measured edge count, stable while o_Valid
//   o_Valid       result available
//   i_Ready       consumer accepts the result when o_Valid & i_Ready
//   o_Overflow    count saturated during this result
//   o_Busy        measurement in progress (state is not IDLE)
//   o_Err         one-cycle pulse when a start names a nonexistent channel
// ---------------------------------------------------------------------------
module ro_freq_meter #(
    parameter int  N_CH   = 4,
    parameter int  CNT_W  = 16,
    parameter int  WIN_W  = 16,
    parameter int  SETTLE = 8,
    localparam int CH_W   = $clog2(N_CH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Start,
    input  logic             i_Stop,
    input  logic             i_Continuous,
    input  logic [CH_W-1:0]  i_Ch_Sel,
    input  logic [WIN_W-1:0] i_Win_Len,
    input  logic [N_CH-1:0]  i_RO_in,
    output logic [N_CH-1:0]  o_RO_Enable,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic             o_Overflow,
    output logic             o_Busy,
    output logic             o_Err
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam logic [CH_W:0] N_CH_L = (CH_W + 1)'(N_CH);
    localparam logic [N_CH-1:0] ONE_HOT_0 = {{(N_CH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_HOLD
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CH_W-1:0]    ch_q;
    logic [CH_W-1:0]    ch_d;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   win_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic               ovf_q;
    logic [N_CH-1:0]    ro_en_q;
    logic [N_CH-1:0]    ro_en_d;
    logic               err_q;
    logic               sync1;
    logic               sync2;
    logic               hist;
    logic               rise;
    logic               ch_bad;
    logic               accept;
    logic               reject;
    logic               start_count;

    assign ch_bad = {1'b0, i_Ch_Sel} >= N_CH_L;
    assign rise   = sync2 & ~hist;

    // Next-state logic. i_Stop is applied last so it overrides every other
    // transition, including an accepted start or a continuous restart.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        reject      = 1'b0;
        start_count = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    if (ch_bad) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_d     = S_COUNT;
                    start_count = 1'b1;
                end
            end
            S_COUNT: begin
                if (win_cnt == WIN_W'(1)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_Ready) begin
                    if (i_Continuous) begin
                        state_d     = S_COUNT;
                        start_count = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_Stop) begin
            state_d     = S_IDLE;
            accept      = 1'b0;
            reject      = 1'b0;
            start_count = 1'b0;
        end
    end

    // The enable is registered from the next state so it rises together with
    // the entry into SETTLE and drops together with the return to IDLE.
    always_comb begin
        ch_d    = accept ? i_Ch_Sel : ch_q;
        ro_en_d = '0;
        if (state_d != S_IDLE) begin
            ro_en_d = ONE_HOT_0 << ch_d;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= S_IDLE;
            ro_en_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ro_en_q <= ro_en_d;
            err_q   <= reject;
        end
    end

    // Channel, window and settle timer are captured when a start is accepted;
    // continuous restarts reuse the captured channel and window.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            ch_q       <= '0;
            win_q      <= '0;
            settle_cnt <= '0;
        end else if (accept) begin
            ch_q       <= i_Ch_Sel;
            win_q      <= (i_Win_Len == '0) ? WIN_W'(1) : i_Win_Len;
            settle_cnt <= SET_W'(SETTLE - 1);
        end else if ((state_q == S_SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
        end
    end

    // Two-flop synchroniser plus history flop on the selected RO. Clearing on
    // SETTLE entry discards whatever the previously selected channel left in
    // the pipeline.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else if (accept) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= i_RO_in[ch_q];
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Window and edge counters. The edge detected during the last window
    // cycle is still counted because the increment happens on the same clock
    // edge that moves the FSM to HOLD. An edge arriving while the counter is
    // already all-ones is lost, which is what sets the sticky overflow flag.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (start_count) begin
            win_cnt  <= win_q;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
        end else if (state_q == S_COUNT) begin
            win_cnt <= win_cnt - WIN_W'(1);
            if (rise) begin
                if (&edge_cnt) begin
                    ovf_q <= 1'b1;
                end else begin
                    edge_cnt <= edge_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_RO_Enable = ro_en_q;
    assign o_Count     = edge_cnt;
    assign o_Overflow  = ovf_q;
    assign o_Valid     = (state_q == S_HOLD);
    assign o_Busy      = (state_q != S_IDLE);
    assign o_Err       = err_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_meter
//
// Scoreboard bench for ro_freq_meter. The stimulus process starts
// measurements and drives the handshake. Each time it begins a window, it
// pushes the expected result into a queue. The bench computes that result
// from the square waves it generates on i_RO_in. A separate monitor pops and
// compares whenever o_Valid rises, checks that the result stays stable while
// held, and checks that the RO enable always names the measured channel.
// ---------------------------------------------------------------------------
module tb_ro_freq_meter;

    localparam int N_CH   = 5;
    localparam int CH_W   = $clog2(N_CH);
    localparam int CNT_W  = 6;
    localparam int WIN_W  = 12;
    localparam int SETTLE = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_Start;
    logic             i_Stop;
    logic             i_Continuous;
    logic [CH_W-1:0]  i_Ch_Sel;
    logic [WIN_W-1:0] i_Win_Len;
    logic [N_CH-1:0]  ro_in;
    logic [N_CH-1:0]  o_RO_Enable;
    logic [CNT_W-1:0] o_Count;
    logic             o_Valid;
    logic             i_Ready;
    logic             o_Overflow;
    logic             o_Busy;
    logic             o_Err;

    typedef struct {
        int cnt;
        bit ovf;
        int vcyc;
    } exp_t;

    exp_t             sbq[$];
    int               per[N_CH];
    int               ph[N_CH];
    int               cyc = 0;
    int               errors = 0;
    int               checks = 0;
    int               cur_ch = 0;
    logic [CNT_W-1:0] held_cnt = '0;
    logic             prev_valid = 1'b0;

    ro_freq_meter #(
        .N_CH   (N_CH),
        .CNT_W  (CNT_W),
        .WIN_W  (WIN_W),
        .SETTLE (SETTLE)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_Start      (i_Start),
        .i_Stop       (i_Stop),
        .i_Continuous (i_Continuous),
        .i_Ch_Sel     (i_Ch_Sel),
        .i_Win_Len    (i_Win_Len),
        .i_RO_in      (ro_in),
        .o_RO_Enable  (o_RO_Enable),
        .o_Count      (o_Count),
        .o_Valid      (o_Valid),
        .i_Ready      (i_Ready),
        .o_Overflow   (o_Overflow),
        .o_Busy       (o_Busy),
        .o_Err        (o_Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Level of RO channel k as seen by the sampling edge n: a square wave of
    // period per[k] that is high for the first half of each period.
    function automatic bit roval(input int k, input int n);
        return ((n + ph[k]) % per[k]) < (per[k] / 2);
    endfunction

    // Drive the value that the next rising clock edge will sample.
    always @(negedge clk) begin
        for (int k = 0; k < N_CH; k++) ro_in[k] = roval(k, cyc + 1);
    end

    // Expected result for a window whose first counting cycle is f. A rising
    // transition first seen at sampling edge n lands in the count after the
    // synchroniser delay. It therefore belongs to this window when n lies in
    // [f-1, f+w-2]. o_Valid is expected in cycle f+w.
    function automatic void pushExp(input int ch, input int f, input int w);
        exp_t e;
        int   n_edges;
        n_edges = 0;
        for (int n = f - 1; n <= f + w - 2; n++) begin
            if (roval(ch, n) && !roval(ch, n - 1)) n_edges++;
        end
        e.cnt  = (n_edges > CMAX) ? CMAX : n_edges;
        e.ovf  = (n_edges > CMAX);
        e.vcyc = f + w;
        sbq.push_back(e);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compares each presented result against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (o_Busy) checkOutput("enable_onehot", 64'(o_RO_Enable), 64'(1) << cur_ch);
            else        checkOutput("enable_idle", 64'(o_RO_Enable), 64'(0));
            if (o_Valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("valid_without_request", 64'(o_Valid), 64'(0));
                end else begin
                    e = sbq.pop_front();
                    checkOutput("count", 64'(o_Count), 64'(e.cnt));
                    checkOutput("overflow", 64'(o_Overflow), 64'(e.ovf));
                    checkOutput("valid_cycle", 64'(cyc), 64'(e.vcyc));
                end
                held_cnt = o_Count;
            end else if (o_Valid) begin
                checkOutput("count_stable", 64'(o_Count), 64'(held_cnt));
            end
            prev_valid = o_Valid;
        end
    end

    task automatic waitValid(input int limit);
        int i;
        i = 0;
        while (!o_Valid && i < limit) begin
            @(negedge clk);
            i++;
        end
        if (!o_Valid) checkOutput("valid_timeout", 64'(o_Valid), 64'(1));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_enable"}, 64'(o_RO_Enable), 64'(0));
        checkOutput({tag, "_count"}, 64'(o_Count), 64'(0));
        checkOutput({tag, "_valid"}, 64'(o_Valid), 64'(0));
        checkOutput({tag, "_overflow"}, 64'(o_Overflow), 64'(0));
        checkOutput({tag, "_busy"}, 64'(o_Busy), 64'(0));
        checkOutput({tag, "_err"}, 64'(o_Err), 64'(0));
    endtask

    // Issue a start, then collect nres results with rdy_dly cycles of stall
    // before each handshake. Continuous mode is dropped for the last one.
    task automatic applyStimulus(input int ch, input int win, input int nres, input int rdy_dly);
        int weff;
        weff = (win == 0) ? 1 : win;
        @(negedge clk);
        i_Ch_Sel     = CH_W'(ch);
        i_Win_Len    = WIN_W'(win);
        i_Continuous = (nres > 1);
        i_Start      = 1'b1;
        cur_ch       = ch;
        pushExp(ch, cyc + SETTLE + 1, weff);
        @(negedge clk);
        i_Start = 1'b0;
        for (int r = 0; r < nres; r++) begin
            waitValid(SETTLE + weff + 10);
            repeat (rdy_dly) @(negedge clk);
            if (r == nres - 1) i_Continuous = 1'b0;
            else               pushExp(ch, cyc + 1, weff);
            i_Ready = 1'b1;
            @(negedge clk);
            i_Ready = 1'b0;
        end
        checkOutput("idle_after_accept_busy", 64'(o_Busy), 64'(0));
    endtask

    task automatic rejectStart(input int ch);
        @(negedge clk);
        i_Ch_Sel = CH_W'(ch);
        i_Win_Len = WIN_W'(10);
        i_Start = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        checkOutput("err_pulse", 64'(o_Err), 64'(1));
        checkOutput("err_busy", 64'(o_Busy), 64'(0));
        @(negedge clk);
        checkOutput("err_single", 64'(o_Err), 64'(0));
        checkOutput("err_busy_after", 64'(o_Busy), 64'(0));
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_Start      = 1'b0;
        i_Stop       = 1'b0;
        i_Continuous = 1'b0;
        i_Ready      = 1'b0;
        i_Ch_Sel     = '0;
        i_Win_Len    = '0;
        ro_in        = '0;
        for (int k = 0; k < N_CH; k++) begin
            per[k] = 6 + k;
            ph[k]  = k;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        // Single shot, period 10, window 100.
        per[2] = 10;
        ph[2]  = 3;
        applyStimulus(2, 100, 1, 2);

        // Saturation: 75 edges into a 6-bit counter.
        per[1] = 4;
        ph[1]  = 1;
        applyStimulus(1, 300, 1, 0);

        // Zero window length behaves as one cycle.
        applyStimulus(3, 0, 1, 1);

        // Long handshake stall.
        applyStimulus(4, 40, 1, 20);

        // Continuous mode, three results.
        per[3] = 5;
        ph[3]  = 2;
        applyStimulus(3, 50, 3, 1);

        // Nonexistent channels are rejected.
        for (int c = N_CH; c < (1 << CH_W); c++) rejectStart(c);

        // A start during COUNT is ignored.
        @(negedge clk);
        i_Ch_Sel  = CH_W'(0);
        i_Win_Len = WIN_W'(60);
        i_Start   = 1'b1;
        cur_ch    = 0;
        pushExp(0, cyc + SETTLE + 1, 60);
        @(negedge clk);
        i_Start = 1'b0;
        repeat (SETTLE + 10) @(negedge clk);
        i_Ch_Sel  = CH_W'(3);
        i_Win_Len = WIN_W'(5);
        i_Start   = 1'b1;
        @(negedge clk);
        i_Start = 1'b0;
        checkOutput("ignored_start_err", 64'(o_Err), 64'(0));
        waitValid(80);
        i_Ready = 1'b1;
        @(negedge clk);
        i_Ready = 1'b0;
        checkOutput("ignored_start_idle", 64'(o_Busy), 64'(0));

        // Stop in the middle of COUNT: no result ever appears.
        @(negedge clk);
        i_Ch_Sel     = CH_W'(1);
        i_Win_Len    = WIN_W'(100);
        i_Continuous = 1'b1;
        i_Start      = 1'b1;
        cur_ch       = 1;
        @(negedge clk);
        i_Start = 1'b0;
        repeat (SETTLE + 30) @(negedge clk);
        i_Stop = 1'b1;
        @(negedge clk);
        i_Stop = 1'b0;
        checkOutput("stop_busy", 64'(o_Busy), 64'(0));
        checkOutput("stop_enable", 64'(o_RO_Enable), 64'(0));
        repeat (120) @(negedge clk);
        checkOutput("stop_no_valid", 64'(o_Valid), 64'(0));

        // Stop together with ready in HOLD wins over continuous restart.
        @(negedge clk);
        i_Ch_Sel     = CH_W'(2);
        i_Win_Len    = WIN_W'(30);
        i_Continuous = 1'b1;
        i_Start      = 1'b1;
        cur_ch       = 2;
        pushExp(2, cyc + SETTLE + 1, 30);
        @(negedge clk);
        i_Start = 1'b0;
        waitValid(SETTLE + 40);
        i_Stop  = 1'b1;
        i_Ready = 1'b1;
        @(negedge clk);
        i_Stop       = 1'b0;
        i_Ready      = 1'b0;
        i_Continuous = 1'b0;
        checkOutput("stop_hold_busy", 64'(o_Busy), 64'(0));
        checkOutput("stop_hold_valid", 64'(o_Valid), 64'(0));
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of SETTLE.
        @(negedge clk);
        i_Ch_Sel  = CH_W'(4);
        i_Win_Len = WIN_W'(50);
        i_Start   = 1'b1;
        cur_ch    = 4;
        @(negedge clk);
        i_Start = 1'b0;
        @(negedge clk);
        checkOutput("settle_busy", 64'(o_Busy), 64'(1));
        #1 rst_n = 1'b0;
        #1 checkAllZero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized measurements against the reference model.
        repeat (30) begin
            for (int k = 0; k < N_CH; k++) begin
                per[k] = $urandom_range(4, 16);
                ph[k]  = $urandom_range(0, per[k] - 1);
            end
            applyStimulus($urandom_range(0, N_CH - 1), $urandom_range(0, 200),
                          $urandom_range(1, 3), $urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
